// File: rtl/ifm_pingpong_bram_wn.sv
// Ping-pong IFM buffer: wide line writes into one bank while the other bank streams narrow words.
// First word appears two edges after a burst is accepted; a 2-entry output FIFO absorbs data_ready stalls.
module ifm_pingpong_bram_wn #(
  parameter int WR_WIDTH = 128,
  parameter int RD_WIDTH = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic                wr_bank_done,
  output logic                wr_ready,
  input  logic                rd_start,
  input  logic [ADDR_W-1:0]   rd_base,
  input  logic [ADDR_W-1:0]   rd_len,
  input  logic                rd_release,
  output logic                rd_bank_ready,
  output logic                rd_busy,
  output logic                rd_done,
  output logic [RD_WIDTH-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                err
);

  localparam int RATIO  = WR_WIDTH / RD_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LINE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RATIO_A = ADDR_W'(RATIO);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic                rel_q, rel_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          full_q, full_d;
  logic                err_q, err_d;

  logic [1:0]          cnt_q;
  logic                pend_q;
  logic                oob_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WR_WIDTH-1:0] rdata_q;
  logic [RD_WIDTH-1:0] fifo_q [2];
  logic                wptr_q, rptr_q;
  logic [1:0]          fcnt_q;

  logic [WR_WIDTH-1:0] mem [2][DEPTH];

  logic                wr_ok, pop, issue, fin, line_oob;
  logic [ADDR_W-1:0]   line_a;
  logic [LANE_W-1:0]   lane_a;
  logic [RD_WIDTH-1:0] lane_word;

  assign wr_ready      = !full_q[wr_bank_q];
  assign wr_ok         = wr_en && wr_ready && (wr_addr < DEPTH_A);
  assign rd_bank_ready = full_q[rd_bank_q];
  assign rd_busy       = (state_q != IDLE);
  assign err           = err_q;

  assign data_valid = (fcnt_q != 2'd0);
  assign data_out   = fifo_q[rptr_q];
  assign pop        = data_valid && data_ready;

  assign line_a   = addr_q / RATIO_A;
  assign lane_a   = LANE_W'(addr_q % RATIO_A);
  assign line_oob = (line_a >= DEPTH_A);

  // A word consumed this cycle frees a slot, so issue can keep pace at one word per cycle.
  assign issue = (state_q == RUN) && ((cnt_q < 2'd2) || pop);
  assign fin   = (state_q == DRAIN) && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
  assign rd_done = fin;

  assign lane_word = oob_q ? '0 : rdata_q[lane_q*RD_WIDTH +: RD_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_bank_q][wr_addr[LINE_W-1:0]] <= wr_data;
    if (issue) rdata_q <= mem[rd_bank_q][line_a[LINE_W-1:0]];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    rel_d     = rel_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    err_d     = err_q;

    if (wr_en && !wr_ok) err_d = 1'b1;
    if (wr_bank_done) begin
      if (wr_ready) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (full_q[rd_bank_q]) begin
            addr_d  = rd_base;
            rem_d   = rd_len;
            rel_d   = rd_release;
            state_d = (rd_len == '0) ? DRAIN : RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
          if (line_oob) err_d = 1'b1;
          if (rem_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Same-bank collision with wr_bank_done cannot set full here: wr_ready was 0 for that bank.
        if (fin) begin
          state_d = IDLE;
          if (rel_q) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rel_q     <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      err_q     <= 1'b0;
      cnt_q     <= 2'd0;
      pend_q    <= 1'b0;
      oob_q     <= 1'b0;
      lane_q    <= '0;
      fifo_q    <= '{default: '0};
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      fcnt_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rel_q     <= rel_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      err_q     <= err_d;
      cnt_q     <= cnt_q + {1'b0, issue} - {1'b0, pop};
      pend_q    <= issue;
      if (issue) begin
        lane_q <= lane_a;
        oob_q  <= line_oob;
      end
      if (pend_q) begin
        fifo_q[wptr_q] <= lane_word;
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifm_pingpong_bram_wn.sv
// Bench for the ping-pong IFM buffer: bank/line reference model feeding a scoreboard of expected words.
module tb_ifm_pingpong_bram_wn;
  localparam int DEPTH = 1024;
  localparam int RATIO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en = 1'b0;
  logic [31:0]  wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         wr_bank_done = 1'b0;
  logic         wr_ready;
  logic         rd_start = 1'b0;
  logic [31:0]  rd_base = '0;
  logic [31:0]  rd_len = '0;
  logic         rd_release = 1'b0;
  logic         rd_bank_ready, rd_busy, rd_done;
  logic [31:0]  data_out;
  logic         data_valid;
  logic         data_ready;
  logic         err;

  ifm_pingpong_bram_wn dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bank_done(wr_bank_done), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_release(rd_release),
    .rd_bank_ready(rd_bank_ready), .rd_busy(rd_busy), .rd_done(rd_done),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: bank contents, fill flags, bank pointers, sticky error.
  logic [127:0] mm [2][DEPTH];
  bit           m_wr_bank, m_rd_bank, m_err;
  bit           m_full [2];
  logic [31:0]  exp_q [$];
  int           n_cmp = 0, n_bad = 0, hs_cnt = 0, rdy_mode = 0;

  function automatic logic [31:0] ref_word(input bit b, input logic [31:0] a);
    logic [31:0] ln;
    int          lane;
    ln   = a / RATIO;
    lane = int'(a % RATIO);
    if (ln >= DEPTH) return '0;
    return mm[b][ln[9:0]][lane*32 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_wr_bank = 0; m_rd_bank = 0; m_err = 0;
    m_full[0] = 0; m_full[1] = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".rd_bank_ready"}, rd_bank_ready, m_full[m_rd_bank]);
    chk({tag, ".wr_ready"}, wr_ready, !m_full[m_wr_bank]);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".rd_busy"}, rd_busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".wr_ready"}, wr_ready, 1'b1);
    chk({tag, ".rd_bank_ready"}, rd_bank_ready, 1'b0);
    chk({tag, ".rd_busy"}, rd_busy, 1'b0);
    chk({tag, ".rd_done"}, rd_done, 1'b0);
    chk({tag, ".data_valid"}, data_valid, 1'b0);
    chk({tag, ".data_out"}, data_out, 32'h0);
    chk({tag, ".err"}, err, 1'b0);
  endtask

  // Called at posedge+1; asserts rst asynchronously mid-cycle.
  task automatic pulse_reset(input bit do_chk);
    #2 rst = 1'b1;
    #1;
    if (do_chk) check_reset_outputs("async_rst");
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (!m_full[m_wr_bank] && a < DEPTH) mm[m_wr_bank][a[9:0]] = d;
    else m_err = 1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_done();
    wr_bank_done = 1'b1;
    if (!m_full[m_wr_bank]) begin
      m_full[m_wr_bank] = 1;
      m_wr_bank = ~m_wr_bank;
    end else begin
      m_err = 1;
    end
    @(posedge clk); #1;
    wr_bank_done = 1'b0;
  endtask

  task automatic fill(input bit pat);
    logic [127:0] d;
    for (int l = 0; l < 16; l++) begin
      if (pat) d = {32'(4*l+3), 32'(4*l+2), 32'(4*l+1), 32'(4*l)};
      else     d = {$urandom, $urandom, $urandom, $urandom};
      do_write(32'(l), d);
    end
  endtask

  task automatic do_burst(input logic [31:0] base, input int len, input bit rel,
                          input int mode, input bit chk_lat);
    bit          acc;
    int          cyc, hs0;
    logic [31:0] a;
    rdy_mode = mode;
    acc = m_full[m_rd_bank];
    if (acc) begin
      for (int i = 0; i < len; i++) begin
        a = base + 32'(i);
        if ((a / RATIO) >= DEPTH) m_err = 1;
        exp_q.push_back(ref_word(m_rd_bank, a));
      end
    end else begin
      m_err = 1;
    end
    hs0 = hs_cnt;
    rd_start = 1'b1; rd_base = base; rd_len = 32'(len); rd_release = rel;
    @(posedge clk); #1;
    rd_start = 1'b0;
    if (acc) begin
      cyc = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) chk("burst.rd_busy", rd_busy, 1'b1);
        if (rd_done) break;
        if (cyc > 2000) begin
          chk("burst.timeout", 1'b0, 1'b1);
          break;
        end
      end
      if (chk_lat) chk("burst.done_cycle", 128'(cyc), 128'((len == 0) ? 1 : len + 2));
      if (rel) begin
        m_full[m_rd_bank] = 0;
        m_rd_bank = ~m_rd_bank;
      end
      @(posedge clk); #1;
      chk("burst.handshakes", 128'(hs_cnt - hs0), 128'(len));
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk("rejected.rd_busy", rd_busy, 1'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  // data_ready driver
  initial begin
    int pc;
    pc = 0;
    data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
      pc++;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold-while-stalled and rd_done alignment.
  initial begin
    bit          stall;
    logic [31:0] held, e;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold.valid", data_valid, 1'b1);
          chk("hold.data", data_out, held);
        end
        if (data_valid && exp_q.size() == 0) begin
          chk("unexpected_valid", data_valid, 1'b0);
        end else if (data_valid && data_ready) begin
          e = exp_q.pop_front();
          chk("data", data_out, e);
        end
        if (data_valid && data_ready) hs_cnt++;
        if (rd_done) chk("done_with_last", 128'(exp_q.size()), 128'(0));
        stall = data_valid && !data_ready;
        held  = data_out;
      end
    end
  end

  initial begin
    #600000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Sequential burst over lines 0..3 with release
    fill(1);
    do_done();
    do_burst(32'd0, 16, 1'b1, 0, 1'b1);
    check_status("seq");

    // Partial burst without release, then a second burst on the same bank
    fill(1);
    do_done();
    do_burst(32'd5, 3, 1'b0, 0, 1'b1);
    check_status("norel");
    do_burst(32'd2, 6, 1'b0, 2, 1'b0);
    check_status("second");

    // Ping-pong: fill bank0 while bank1 streams
    fork
      do_burst(32'd0, 40, 1'b1, 2, 1'b0);
      begin
        fill(0);
        do_done();
      end
    join
    check_status("pingpong");
    fill(0);
    do_done();
    do_write(32'd0, {4{32'hDEAD_BEEF}});
    check_status("both_full");

    // Stalls in a 1,0,0,1 pattern; the dropped write must not show up
    do_burst(32'd0, 8, 1'b1, 1, 1'b0);
    check_status("stall");

    // Zero-length burst still releases
    do_burst(32'd7, 0, 1'b1, 0, 1'b1);
    check_status("len0");

    // Reset in the middle of a burst
    fill(0);
    do_done();
    for (int i = 0; i < 30; i++) exp_q.push_back(ref_word(m_rd_bank, 32'(3 + i)));
    rdy_mode = 0;
    rd_start = 1'b1; rd_base = 32'd3; rd_len = 32'd30; rd_release = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    pulse_reset(1'b1);
    check_status("after_rst");

    // Normal operation after reset, then out-of-range and wrapping addresses
    fill(0);
    do_write(32'd1023, {$urandom, $urandom, $urandom, $urandom});
    do_done();
    do_burst(32'd0, 64, 1'b0, 2, 1'b0);
    check_status("post_rst_read");
    do_burst(32'd4094, 4, 1'b0, 0, 1'b1);
    check_status("oob");
    do_burst(32'hFFFF_FFFE, 4, 1'b1, 2, 1'b0);
    check_status("wrap");

    // Start on an empty bank
    pulse_reset(1'b0);
    do_burst(32'd0, 4, 1'b0, 0, 1'b0);
    check_status("empty_start");

    // Randomised rounds
    for (int r = 0; r < 8; r++) begin
      fill(0);
      if ($urandom_range(0, 3) != 0) do_done();
      do_burst(32'($urandom_range(0, 40)), int'($urandom_range(0, 23)),
               1'($urandom_range(0, 1)), 2, 1'b0);
      check_status("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
